// File: rtl/view_buffer_pp.sv
// view_buffer_pp: double-buffered parallel-in/serial-out view buffer.
// A whole view is written into the shadow bank in one cycle. The active bank
// streams out one element per handshake, element 0 first. When the active
// bank empties and the shadow holds a view, the banks swap roles.
module view_buffer_pp #(
  parameter int ELEM_W    = 8,
  parameter int NUM_ELEMS = 16,
  parameter int LEN_W     = $clog2(NUM_ELEMS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ELEM_W*NUM_ELEMS-1:0] in_data,
  input  logic [LEN_W-1:0]            in_len,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ELEM_W-1:0]           out_data,
  output logic [LEN_W-1:0]            out_remaining,
  output logic                        shadow_full
);

  typedef logic [ELEM_W-1:0] elem_t;

  elem_t            bank0     [NUM_ELEMS];
  elem_t            bank1     [NUM_ELEMS];
  elem_t            bank0Next [NUM_ELEMS];
  elem_t            bank1Next [NUM_ELEMS];
  elem_t            shift0    [NUM_ELEMS];
  elem_t            shift1    [NUM_ELEMS];
  elem_t            loadView  [NUM_ELEMS];

  logic [LEN_W-1:0] cnt0, cnt1, cnt0Next, cnt1Next;
  logic [LEN_W-1:0] actCnt, shCnt, actNext, shNext, loadLen;
  logic             sel, selNext;
  logic             pop, load, swap;

  // Output decode: pure functions of the registered state.
  always_comb begin
    actCnt        = sel ? cnt1 : cnt0;
    shCnt         = sel ? cnt0 : cnt1;
    out_valid     = (actCnt != '0);
    in_ready      = (shCnt == '0);
    shadow_full   = (shCnt != '0);
    out_remaining = actCnt;
    out_data      = sel ? bank1[0] : bank0[0];
  end

  // Next-state computation for both banks, their counts and the select bit.
  always_comb begin
    pop     = out_valid & out_ready;
    load    = in_valid & in_ready & (in_len != '0);
    loadLen = (in_len > LEN_W'(NUM_ELEMS)) ? LEN_W'(NUM_ELEMS) : in_len;

    for (int unsigned i = 0; i < NUM_ELEMS; i++) begin
      loadView[i] = (LEN_W'(i) < loadLen) ?
                    in_data[ELEM_W*(NUM_ELEMS-i)-1 -: ELEM_W] : '0;
    end

    for (int unsigned i = 0; i < NUM_ELEMS - 1; i++) begin
      shift0[i] = bank0[i+1];
      shift1[i] = bank1[i+1];
    end
    shift0[NUM_ELEMS-1] = '0;
    shift1[NUM_ELEMS-1] = '0;

    bank0Next = bank0;
    bank1Next = bank1;
    if (pop) begin
      if (sel) bank1Next = shift1;
      else     bank0Next = shift0;
    end
    if (load) begin
      if (sel) bank0Next = loadView;
      else     bank1Next = loadView;
    end

    // Banks never move physically; a swap only flips sel, so the drained
    // bank (count 0, contents all zero) becomes the new empty shadow.
    actNext = actCnt - LEN_W'(pop);
    shNext  = load ? loadLen : shCnt;
    swap    = (actNext == '0) && (shNext != '0);
    selNext = sel ^ swap;

    if (sel) begin
      cnt1Next = actNext;
      cnt0Next = shNext;
    end else begin
      cnt0Next = actNext;
      cnt1Next = shNext;
    end
  end

  // State registers with async reset and synchronous flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_ELEMS; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
      cnt0 <= '0;
      cnt1 <= '0;
      sel  <= 1'b0;
    end else if (flush) begin
      for (int unsigned i = 0; i < NUM_ELEMS; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
      cnt0 <= '0;
      cnt1 <= '0;
      sel  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_ELEMS; i++) begin
        bank0[i] <= bank0Next[i];
        bank1[i] <= bank1Next[i];
      end
      cnt0 <= cnt0Next;
      cnt1 <= cnt1Next;
      sel  <= selNext;
    end
  end

endmodule

// File: doc/view_buffer_pp.md
Name: view_buffer_pp

Overview:
- Parametrised, double-buffered parallel-in/serial-out view buffer for the CNN datapath.
- Accepts a full window ("view") of NUM_ELEMS elements in one cycle and streams it out one element per handshake, MSB element first.
- A shadow bank lets the next view load while the current one drains, so back-to-back views stream with no bubble.
- Adds a variable view length, a valid/ready handshake on both sides, and a synchronous flush.

Parameters:
- ELEM_W, 8, width of one element in bits.
- NUM_ELEMS, 16, elements per view (bank depth); must be >= 2.
- LEN_W, $clog2(NUM_ELEMS+1), width of the length and count fields.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of both banks.
- in_valid  in  1  a view is offered on in_data.
- in_ready  out  1  the buffer can accept a view this cycle.
- in_data  in  ELEM_W*NUM_ELEMS  view; element 0 = in_data[ELEM_W*NUM_ELEMS-1 -: ELEM_W].
- in_len  in  LEN_W  number of valid leading elements in the view.
- out_valid  out  1  out_data holds a valid element.
- out_ready  in  1  consumer takes out_data this cycle.
- out_data  out  ELEM_W  current head element of the active bank.
- out_remaining  out  LEN_W  elements left in the active bank, including the head.
- shadow_full  out  1  the shadow bank holds a pending view.

Behaviour:
- State:
  - two banks B0/B1, each NUM_ELEMS x ELEM_W, with a count cnt0/cnt1;
  - a select bit sel (active bank = Bsel, shadow = B!sel).
- Reset (rst=0, asynchronous) and flush=1 (synchronous) clear:
  - banks to 0, counts to 0, sel to 0;
  - out_valid=0, out_data=0, out_remaining=0, in_ready=1, shadow_full=0.
  - flush overrides load and pop in the same cycle.
  - Reset takes effect mid-stream with no completion of the current view.
- Output signals are direct register decodes with no combinational path from out_ready or in_valid:
  - out_valid = (active cnt != 0)
  - out_data = active bank element 0
  - out_remaining = active cnt
  - in_ready = (shadow cnt == 0)
  - shadow_full = !in_ready
- Invariant: active cnt == 0 implies shadow cnt == 0.
- pop = out_valid & out_ready:
  - the active bank shifts toward element 0 by one element;
  - the vacated tail is filled with 0 (never X);
  - active cnt decrements.
- load = in_valid & in_ready & (in_len != 0):
  - in_data is written into the shadow bank;
  - shadow cnt = min(in_len, NUM_ELEMS);
  - elements at index >= length are stored as 0.
  - in_len == 0 is accepted (handshake completes) with no state change.
  - in_len > NUM_ELEMS clamps to NUM_ELEMS.
- Swap rule, evaluated at every edge:
  - next_act = active cnt - pop;
  - if next_act == 0 and the shadow is nonempty after this edge (existing or being loaded), sel toggles;
  - the new active bank is the shadow contents and the new shadow cnt is 0.
- Latency:
  - a load into an empty buffer gives out_valid=1 on the cycle after the accepting edge;
  - a pop of the last element with the shadow full presents the shadow's element 0 on the next cycle, with no bubble.
- Simultaneous events:
  - load and pop in the same cycle are both honoured;
  - load together with the last pop swaps the new view straight to active;
  - load while the shadow is full is impossible, because in_ready=0.
- Throughput: one element per cycle sustained; a new view is accepted every len cycles when len >= 2.
- Counts never underflow: pop requires cnt != 0.

Test Plan:
- Reset then idle: rst low, release -> out_valid=0, in_ready=1, out_data=0x00, out_remaining=0.
- Single view, in_data=0x0F0E...01_00 (element k = 15-k), in_len=16, out_ready=1 -> out_valid rises one cycle after load; out_data sequence 0x0F..0x00 over 16 consecutive cycles; then out_valid=0.
- Back-to-back views, each len 16: load A, then load B while A drains (in_ready drops after B's load) -> 32 consecutive valid outputs, no bubble; in_ready returns to 1 on the cycle B becomes active.
- Short length and clamp: in_len=3 -> exactly 3 elements then out_valid=0; in_len=20 -> 16 elements; in_len=0 -> handshake completes, out_valid stays 0.
- Backpressure: out_ready toggled 1,0,0,1 -> out_data holds during stalls, no element lost or duplicated, out_remaining decrements only on pops.
- Flush and reset mid-stream: flush after 5 of 16 elements with the shadow full -> next cycle out_valid=0, in_ready=1, out_remaining=0; repeat with async rst asserted between edges -> outputs clear immediately.
